// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF/ID queue
interface if_id_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
);
  logic                         flush;
  logic                         in_valid;
  logic [XLEN-1:0]              in_pc;
  logic [31:0]                  in_instr;
  logic                         in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [XLEN-1:0]              out_pc;
  logic [31:0]                  out_instr;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular-buffer FIFO decoupling instruction fetch from decode
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h00000013;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Ready depends only on occupancy, so a full queue refuses even when decode pops.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = q.in_valid && !full && !q.flush;
  assign pop   = !empty && q.out_ready && !q.flush;

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Payload storage carries no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr]    <= q.in_pc;
      instr_mem[wr_ptr] <= q.in_instr;
    end
  end

  assign q.in_ready  = !full;
  assign q.out_valid = !empty;
  assign q.count     = count_q;
  assign q.out_pc    = empty ? '0  : pc_mem[rd_ptr];
  assign q.out_instr = empty ? NOP : instr_mem[rd_ptr];
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  if_id_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] instr_for(input logic [XLEN-1:0] pc);
    return 32'hA000_0000 | pc[31:0];
  endfunction

  task automatic push_one(input logic [XLEN-1:0] pc);
    bus.in_valid  = 1'b1;
    bus.in_pc     = pc;
    bus.in_instr  = instr_for(pc);
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_pc !== 64'h0) begin errors++; $display("FAIL reset_out_pc got %0h exp 0", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h00000013) begin errors++; $display("FAIL reset_out_instr got %h exp 00000013", bus.out_instr); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] instrs [4];
    instrs[0] = 32'h00100093; instrs[1] = 32'h00200113;
    instrs[2] = 32'h00300193; instrs[3] = 32'h00400213;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_pc     = 64'(4 * i);
      bus.in_instr  = instrs[i];
      bus.out_ready = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * i)) begin
        errors++; $display("FAIL drain_pc[%0d] got v=%b pc=%0h exp v=1 pc=%0h", i, bus.out_valid, bus.out_pc, 4 * i);
      end
      checks++; if (bus.out_instr !== instrs[i]) begin
        errors++; $display("FAIL drain_instr[%0d] got %h exp %h", i, bus.out_instr, instrs[i]);
      end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h00000013) begin
      errors++; $display("FAIL drain_empty got v=%b instr=%h exp v=0 instr=00000013", bus.out_valid, bus.out_instr);
    end
    idle();
  endtask

  task automatic test_latency();
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h100;
    bus.in_instr  = instr_for(64'h100);
    bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n got %b exp 0", bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h100) begin
      errors++; $display("FAIL lat_n1 got v=%b pc=%0h exp v=1 pc=100", bus.out_valid, bus.out_pc);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n2 got %b exp 0", bus.out_valid); end
    idle();
  endtask

  task automatic test_back_to_back();
    push_one(64'h10);
    push_one(64'h14);
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h20;
    bus.in_instr  = instr_for(64'h20);
    bus.out_ready = 1'b1;
    checks++; if (bus.out_pc !== 64'h10) begin errors++; $display("FAIL b2b_head0 got %0h exp 10", bus.out_pc); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", bus.count); end
    checks++; if (bus.out_pc !== 64'h14) begin errors++; $display("FAIL b2b_head1 got %0h exp 14", bus.out_pc); end
    tick();
    checks++; if (bus.out_pc !== 64'h20 || bus.out_instr !== instr_for(64'h20)) begin
      errors++; $display("FAIL b2b_head2 got pc=%0h instr=%h exp pc=20 instr=%h", bus.out_pc, bus.out_instr, instr_for(64'h20));
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", bus.out_valid); end
    for (int i = 0; i < 4; i++) push_one(64'h30 + 64'(4 * i));
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h50;
    bus.in_instr  = instr_for(64'h50);
    bus.out_ready = 1'b1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_count got %0d exp 3", bus.count); end
    checks++; if (bus.out_pc !== 64'h34) begin errors++; $display("FAIL full_head got %0h exp 34", bus.out_pc); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_pc !== 64'h34 + 64'(4 * i)) begin
        errors++; $display("FAIL full_drain[%0d] got %0h exp %0h", i, bus.out_pc, 64'h34 + 64'(4 * i));
      end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_refused got v=%b pc=%0h exp v=0", bus.out_valid, bus.out_pc); end
    idle();
  endtask

  task automatic test_flush();
    push_one(64'h60);
    push_one(64'h64);
    push_one(64'h68);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h40;
    bus.in_instr  = instr_for(64'h40);
    bus.out_ready = 1'b1;
    tick();
    idle();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
    push_one(64'h200);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h200) begin
      errors++; $display("FAIL flush_first got v=%b pc=%0h exp v=1 pc=200", bus.out_valid, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got v=%b pc=%0h exp v=0", bus.out_valid, bus.out_pc); end
    idle();
  endtask

  task automatic test_wrap();
    int got = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.in_valid = (cyc < 10);
      bus.in_pc    = 64'(4 * cyc);
      bus.in_instr = instr_for(64'(4 * cyc));
      if (bus.count > 3'd4) begin
        checks++; errors++; $display("FAIL wrap_count got %0d exp <=4", bus.count);
      end
      if (bus.out_valid === 1'b1) begin
        checks++; if (got >= 10 || bus.out_pc !== 64'(4 * got) || bus.out_instr !== instr_for(64'(4 * got))) begin
          errors++; $display("FAIL wrap_out[%0d] got pc=%0h instr=%h exp pc=%0h", got, bus.out_pc, bus.out_instr, 4 * got);
        end
        got++;
      end
      tick();
    end
    checks++; if (got !== 10) begin errors++; $display("FAIL wrap_total got %0d exp 10", got); end
    idle();
  endtask

  task automatic test_reset_mid();
    push_one(64'h80);
    push_one(64'h84);
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL rstmid_pre got %0d exp 2", bus.count); end
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc    = 64'h300;
    bus.in_instr = instr_for(64'h300);
    tick();
    rst = 1'b0;
    idle();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_pc !== 64'h0) begin errors++; $display("FAIL rstmid_out_pc got %0h exp 0", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h00000013) begin errors++; $display("FAIL rstmid_out_instr got %h exp 00000013", bus.out_instr); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale got v=%b pc=%0h exp v=0", bus.out_valid, bus.out_pc); end
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
